// File: rtl/egg_pkg.sv
// Shared widths, response id width and FSM state encoding for the egg hash-core scheduler.
package egg_pkg;

  localparam int HDR_W  = 512;
  localparam int HASH_W = 256;
  localparam int ID_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Round-robin pointer advance: one past the winner, wrapping at n.
  function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] idx, input int n);
    return (int'(idx) + 1 >= n) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/egg_rr_arb.sv
// Round-robin arbiter: picks the first requester at or above ptr, wrapping around.
module egg_rr_arb
  import egg_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] winner,
  output logic            any
);

  int best_d;
  int best_j;
  int d;

  // NOTE: every combinational output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    best_d = NREQ;
    best_j = 0;
    d      = 0;
    grant  = '0;
    for (int j = 0; j < NREQ; j++) begin
      // Distance from the pointer going upward; smallest requesting distance wins.
      d = j - int'(ptr);
      if (d < 0) d = d + NREQ;
      if (req[j] && d < best_d) begin
        best_d = d;
        best_j = j;
      end
    end
    any    = (best_d < NREQ);
    winner = any ? ID_W'(best_j) : '0;
    for (int j = 0; j < NREQ; j++) begin
      grant[j] = any && (best_j == j);
    end
  end

endmodule

// File: rtl/egg_sched.sv
// Job scheduler for one shared egg hash core, one job in flight at a time.
// Optional per-job watchdog enabled by defining EGG_SCHED_TIMEOUT_EN.
module egg_sched
  import egg_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 80
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*HDR_W-1:0]  req_header,
  output logic [NREQ-1:0]        req_ready,
  output logic                   core_start,
  output logic [HDR_W-1:0]       core_header,
  input  logic                   core_done,
  input  logic [HASH_W-1:0]      core_hash,
  output logic                   core_abort,
  output logic                   rsp_valid,
  output logic [2:0]             rsp_id,
  output logic [HASH_W-1:0]      rsp_hash,
  output logic                   rsp_timeout,
  input  logic                   rsp_ready,
  output logic                   busy
);

  state_t           state;
  logic [ID_W-1:0]  ptr;
  logic [NREQ-1:0]  grant;
  logic [ID_W-1:0]  winner;
  logic             any;
  logic [HDR_W-1:0] hdr_sel;
  logic             expire;

  egg_rr_arb #(.NREQ(NREQ)) u_arb (
    .req    (req_valid),
    .ptr    (ptr),
    .grant  (grant),
    .winner (winner),
    .any    (any)
  );

  always_comb begin
    hdr_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) hdr_sel = req_header[i*HDR_W +: HDR_W];
    end
  end

`ifdef EGG_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;

  // Counts WAIT cycles from 0; a core_done on the final cycle still wins.
  assign expire = (state == ST_WAIT) && !core_done && (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || state != ST_WAIT) wait_cnt <= '0;
    else                         wait_cnt <= wait_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else if (state == ST_WAIT) begin
      if (core_done)   timeout_q <= 1'b0;
      else if (expire) timeout_q <= 1'b1;
    end
  end

  // A reset during WAIT discards the job silently; the system resets the core itself.
  assign core_abort  = expire && !rst;
  assign rsp_timeout = timeout_q;
`else
  assign expire      = 1'b0;
  assign core_abort  = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: the wide header/hash holding registers are reset too, because zero is their visible reset value on the ports.
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      core_header <= '0;
      rsp_id      <= '0;
      rsp_hash    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (any) begin
            state       <= ST_ISSUE;
            ptr         <= rr_next(winner, NREQ);
            core_header <= hdr_sel;
            rsp_id      <= winner;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (core_done) begin
            rsp_hash <= core_hash;
            state    <= ST_RESP;
          end else if (expire) begin
            rsp_hash <= '0;
            state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state == ST_IDLE && !rst) ? grant : '0;
  assign core_start = (state == ST_ISSUE);
  assign rsp_valid  = (state == ST_RESP);
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_egg_sched.sv
// Scoreboard bench for egg_sched: grants and responses are queued at issue time and
// popped by independent negedge monitors; a behavioural core answers core_start.
module tb_egg_sched;
  import egg_pkg::*;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 80;
  localparam logic [HASH_W-1:0] SALT = {8{32'h5a5a0f0f}};

  typedef struct packed {
    logic [2:0]        id;
    logic [HASH_W-1:0] hash;
    logic              to;
  } rsp_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*HDR_W-1:0] req_header;
  logic [NREQ-1:0]       req_ready;
  logic                  core_start;
  logic [HDR_W-1:0]      core_header;
  logic                  core_done;
  logic [HASH_W-1:0]     core_hash;
  logic                  core_abort;
  logic                  rsp_valid;
  logic [2:0]            rsp_id;
  logic [HASH_W-1:0]     rsp_hash;
  logic                  rsp_timeout;
  logic                  rsp_ready;
  logic                  busy;

  egg_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_header  (req_header),
    .req_ready   (req_ready),
    .core_start  (core_start),
    .core_header (core_header),
    .core_done   (core_done),
    .core_hash   (core_hash),
    .core_abort  (core_abort),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_hash    (rsp_hash),
    .rsp_timeout (rsp_timeout),
    .rsp_ready   (rsp_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [HDR_W-1:0] hdr_tab [NREQ];
  rsp_t exp_rsp_q [$];
  int   exp_grant_q [$];
  int   grant_hist [$];
  int   n_grants = 0;
  int   last_grant_cyc = 0;
  int   last_start_cyc = 0;
  int   last_abort_cyc = 0;
  int   abort_cnt = 0;

  // Core model controls
  int                core_lat   = 1;   // 0 means the core never answers
  logic              core_fixed = 1'b0;
  logic [HASH_W-1:0] core_rsp   = '0;
  int                stray_req  = 0;

  task automatic check(input string name, input logic [HASH_W-1:0] act, input logic [HASH_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic rsp_t mk_rsp(input int id, input logic [HASH_W-1:0] h, input logic to);
    rsp_t r;
    r.id   = 3'(id);
    r.hash = h;
    r.to   = to;
    return r;
  endfunction

  function automatic logic [HDR_W-1:0] make_hdr(input int i);
    logic [31:0] w;
    w = 32'(32'h11111111 * (i + 1)) ^ 32'hc0de0000;
    return {16{w}};
  endfunction

  // Behavioural hash core
  initial begin
    int lat;
    int stray_seen;
    stray_seen = 0;
    core_done  = 1'b0;
    core_hash  = '0;
    forever begin
      @(negedge clk);
      if (core_start && core_lat != 0) begin
        lat = core_lat;
        repeat (lat) @(posedge clk);
        #1;
        core_done = 1'b1;
        core_hash = core_fixed ? core_rsp : (core_header[HASH_W-1:0] ^ SALT);
        @(posedge clk);
        #1;
        core_done = 1'b0;
        core_hash = '0;
      end else if (stray_req != stray_seen) begin
        stray_seen = stray_req;
        @(posedge clk);
        #1;
        core_done = 1'b1;
        core_hash = {8{32'hffff0000}};
        @(posedge clk);
        #1;
        core_done = 1'b0;
        core_hash = '0;
      end
    end
  end

  // Grant monitor
  always @(negedge clk) begin
    int eg;
    if (req_ready != '0) begin
      check("grant_onehot", HASH_W'($onehot(req_ready)), HASH_W'(1));
      if (exp_grant_q.size() == 0) begin
        check("unexpected_grant", HASH_W'(req_ready), HASH_W'(0));
      end else begin
        eg = exp_grant_q.pop_front();
        check("grant_id", HASH_W'(req_ready), HASH_W'(1) << eg);
      end
      last_grant_cyc = cyc;
      grant_hist.push_back(cyc);
      n_grants++;
    end
  end

  // Start / abort monitor
  always @(negedge clk) begin
    if (core_start) begin
      check("start_after_grant", HASH_W'(cyc - last_grant_cyc), HASH_W'(1));
      last_start_cyc = cyc;
    end
    if (core_abort) begin
      abort_cnt++;
      last_abort_cyc = cyc;
    end
  end

  // Response monitor with hold-stability checking under backpressure
  logic hold_prev = 1'b0;
  rsp_t prev_rsp;
  always @(negedge clk) begin
    rsp_t er;
    if (rsp_valid) begin
      if (hold_prev) begin
        check("rsp_id_stable", HASH_W'(rsp_id), HASH_W'(prev_rsp.id));
        check("rsp_hash_stable", rsp_hash, prev_rsp.hash);
        check("rsp_to_stable", HASH_W'(rsp_timeout), HASH_W'(prev_rsp.to));
      end
      if (rsp_ready) begin
        if (exp_rsp_q.size() == 0) begin
          check("unexpected_rsp", HASH_W'(1), HASH_W'(0));
        end else begin
          er = exp_rsp_q.pop_front();
          check("rsp_id", HASH_W'(rsp_id), HASH_W'(er.id));
          check("rsp_hash", rsp_hash, er.hash);
          check("rsp_timeout", HASH_W'(rsp_timeout), HASH_W'(er.to));
        end
        hold_prev = 1'b0;
      end else begin
        hold_prev = 1'b1;
        prev_rsp  = mk_rsp(int'(rsp_id), rsp_hash, rsp_timeout);
      end
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic wait_grant(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (req_ready != '0) return;
    end
    check(name, HASH_W'(0), HASH_W'(1));
  endtask

  task automatic wait_start(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (core_start) return;
    end
    check(name, HASH_W'(0), HASH_W'(1));
  endtask

  task automatic wait_rsp(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rsp_valid) return;
    end
    check(name, HASH_W'(0), HASH_W'(1));
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && exp_rsp_q.size() == 0 && exp_grant_q.size() == 0) return;
    end
    check(name, HASH_W'(0), HASH_W'(1));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req_ready"}, HASH_W'(req_ready), HASH_W'(0));
    check({tag, "_core_start"}, HASH_W'(core_start), HASH_W'(0));
    check({tag, "_core_abort"}, HASH_W'(core_abort), HASH_W'(0));
    check({tag, "_rsp_valid"}, HASH_W'(rsp_valid), HASH_W'(0));
    check({tag, "_rsp_id"}, HASH_W'(rsp_id), HASH_W'(0));
    check({tag, "_rsp_hash"}, rsp_hash, HASH_W'(0));
    check({tag, "_rsp_timeout"}, HASH_W'(rsp_timeout), HASH_W'(0));
    check({tag, "_core_header"}, HASH_W'(|core_header), HASH_W'(0));
    check({tag, "_busy"}, HASH_W'(busy), HASH_W'(0));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int abort_before;
    req_valid  = '0;
    rsp_ready  = 1'b1;
    req_header = '0;
    for (int i = 0; i < NREQ; i++) hdr_tab[i] = make_hdr(i);
    hdr_tab[2] = {64{8'ha5}};
    for (int i = 0; i < NREQ; i++) req_header[i*HDR_W +: HDR_W] = hdr_tab[i];

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("reset");

    // Stray core_done in IDLE is ignored
    @(posedge clk);
    #1 stray_req++;
    repeat (4) begin
      @(negedge clk);
      check("stray_busy", HASH_W'(busy), HASH_W'(0));
      check("stray_rsp_valid", HASH_W'(rsp_valid), HASH_W'(0));
    end
    check("stray_rsp_hash", rsp_hash, HASH_W'(0));

    // Single job from requester 2, 64-cycle core
    core_fixed = 1'b1;
    core_rsp   = HASH_W'(256'h1234);
    core_lat   = 64;
    exp_grant_q.push_back(2);
    exp_rsp_q.push_back(mk_rsp(2, HASH_W'(256'h1234), 1'b0));
    @(posedge clk);
    #1 req_valid = 4'b0100;
    wait_grant("job1_grant_wait", 5);
    check("job1_ready", HASH_W'(req_ready), HASH_W'(4'b0100));
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check("job1_start", HASH_W'(core_start), HASH_W'(1));
    check("job1_hdr_lo", core_header[HASH_W-1:0], hdr_tab[2][HASH_W-1:0]);
    check("job1_hdr_hi", core_header[HDR_W-1:HASH_W], hdr_tab[2][HDR_W-1:HASH_W]);
    @(negedge clk);
    check("job1_start_once", HASH_W'(core_start), HASH_W'(0));
    check("job1_busy", HASH_W'(busy), HASH_W'(1));
    wait_idle("job1_done_wait", 200);

    // Fairness: all four held, 1-cycle core, minimum turnaround
    do_reset();
    core_fixed = 1'b0;
    core_lat   = 1;
    for (int k = 0; k < 5; k++) begin
      exp_grant_q.push_back(k % 4);
      exp_rsp_q.push_back(mk_rsp(k % 4, hdr_tab[k % 4][HASH_W-1:0] ^ SALT, 1'b0));
    end
    grant_hist.delete();
    n_grants = 0;
    @(posedge clk);
    #1 req_valid = '1;
    for (int i = 0; i < 60 && n_grants < 5; i++) @(negedge clk);
    check("fair_grant_count", HASH_W'(n_grants), HASH_W'(5));
    @(posedge clk);
    #1 req_valid = '0;
    wait_idle("fair_done_wait", 60);
    for (int k = 1; k < grant_hist.size(); k++)
      check("fair_turnaround", HASH_W'(grant_hist[k] - grant_hist[k-1]), HASH_W'(4));

    // Backpressure: 1 and 3 requesting, pointer now at 1
    rsp_ready = 1'b0;
    exp_grant_q.push_back(1);
    exp_grant_q.push_back(3);
    exp_rsp_q.push_back(mk_rsp(1, hdr_tab[1][HASH_W-1:0] ^ SALT, 1'b0));
    exp_rsp_q.push_back(mk_rsp(3, hdr_tab[3][HASH_W-1:0] ^ SALT, 1'b0));
    @(posedge clk);
    #1 req_valid = 4'b1010;
    wait_grant("bp_grant_wait", 5);
    @(posedge clk);
    #1 req_valid = 4'b1000;
    wait_rsp("bp_rsp_wait", 20);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_no_grant", HASH_W'(req_ready), HASH_W'(0));
      check("bp_rsp_valid", HASH_W'(rsp_valid), HASH_W'(1));
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_grant("bp_grant2_wait", 10);
    @(posedge clk);
    #1 req_valid = '0;
    wait_idle("bp_done_wait", 40);

    // Reset on WAIT cycle 30 discards the job
    core_lat     = 0;
    abort_before = abort_cnt;
    exp_grant_q.push_back(0);
    @(posedge clk);
    #1 req_valid = 4'b0001;
    wait_grant("rw_grant_wait", 5);
    @(posedge clk);
    #1 req_valid = '0;
    wait_start("rw_start_wait", 5);
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rw_abort_in_rst", HASH_W'(core_abort), HASH_W'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("rw");
    repeat (5) begin
      @(negedge clk);
      check("rw_no_rsp", HASH_W'(rsp_valid), HASH_W'(0));
    end
    check("rw_abort_cnt", HASH_W'(abort_cnt - abort_before), HASH_W'(0));

`ifdef EGG_SCHED_TIMEOUT_EN
    // Core never answers: abort 80 cycles into WAIT
    abort_before = abort_cnt;
    exp_grant_q.push_back(2);
    exp_rsp_q.push_back(mk_rsp(2, HASH_W'(0), 1'b1));
    @(posedge clk);
    #1 req_valid = 4'b0100;
    wait_grant("to_grant_wait", 5);
    @(posedge clk);
    #1 req_valid = '0;
    wait_start("to_start_wait", 5);
    wait_rsp("to_rsp_wait", 120);
    check("to_abort_cnt", HASH_W'(abort_cnt - abort_before), HASH_W'(1));
    check("to_abort_cycle", HASH_W'(last_abort_cyc - last_start_cyc), HASH_W'(80));
    wait_idle("to_done_wait", 10);

    // core_done on the 80th WAIT cycle completes normally
    core_fixed   = 1'b1;
    core_rsp     = HASH_W'(256'hbeef);
    core_lat     = 80;
    abort_before = abort_cnt;
    exp_grant_q.push_back(3);
    exp_rsp_q.push_back(mk_rsp(3, HASH_W'(256'hbeef), 1'b0));
    @(posedge clk);
    #1 req_valid = 4'b1000;
    wait_grant("tl_grant_wait", 5);
    @(posedge clk);
    #1 req_valid = '0;
    wait_idle("tl_done_wait", 120);
    check("tl_abort_cnt", HASH_W'(abort_cnt - abort_before), HASH_W'(0));
`endif

    check("final_grant_q_empty", HASH_W'(exp_grant_q.size()), HASH_W'(0));
    check("final_rsp_q_empty", HASH_W'(exp_rsp_q.size()), HASH_W'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
